pow_n_pipelined_with_flow_control: RTL
======================================

POW_N_PIPELINED_WITH_FLOW_CONTROL -- requirements
Module: pow_n_pipelined_with_flow_control

Interface
REQ-001 The block SHALL have parameter width, default 8, the operand and result bit width (legal range >= 1).
REQ-002 The block SHALL have parameter n, default 5, the exponent (legal range >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port up_vld, input, 1 bit, upstream data valid.
REQ-006 The block SHALL have port up_rdy, output, 1 bit, block can accept upstream data this cycle.
REQ-007 The block SHALL have port up_data, input, width bits, the operand x.
REQ-008 The block SHALL have port down_vld, output, 1 bit, result valid.
REQ-009 The block SHALL have port down_rdy, input, 1 bit, downstream accepts the result this cycle.
REQ-010 The block SHALL have port down_data, output, width bits, the result x^n mod 2^width.

Function
REQ-011 The block SHALL have exactly n pipeline stages: stage 0 registers x; stage k (1..n-1) registers x and x^(k+1); stage n-1 drives down_vld/down_data.
REQ-012 Each stage SHALL hold one valid bit, one width-bit copy of x, and one width-bit partial product.
REQ-013 A transfer SHALL occur on a port only in a cycle where vld and rdy are both 1.
REQ-014 Stage i SHALL be ready when it is empty or stage i+1 is ready (stage n-1: when down_rdy=1); up_rdy SHALL equal stage 0 ready, combinationally.
REQ-015 With down_rdy held 1, the block SHALL accept one operand per cycle and present its result n cycles after acceptance (n=1: down_data=x one cycle later).
REQ-016 A stage that holds valid data and whose successor is not ready SHALL hold its data and valid bit unchanged.
REQ-017 Each multiply SHALL keep only the low width bits of the 2*width-bit product.
REQ-018 Results SHALL leave in acceptance order, with no loss and no duplication.
REQ-019 When full (all n stages valid, down_rdy=0), up_rdy SHALL be 0; a down transfer in the same cycle SHALL make up_rdy 1 in that cycle.
REQ-020 up_vld and up_data SHALL be ignored when up_rdy=0; down_data SHALL be stable while down_vld=1 and down_rdy=0.
REQ-021 up_rdy SHALL NOT depend combinationally on up_vld.

Reset
REQ-022 When rst=1 at a clock edge, all stage valid bits SHALL clear, so down_vld=0 and up_rdy=1 in the following cycle.
REQ-023 Reset SHALL also clear all data and partial-product registers to 0, so down_data=0 after reset.
REQ-024 Reset mid-operation SHALL discard all in-flight items; none SHALL appear at the output afterwards.
REQ-025 In a cycle where rst=1, no up transfer SHALL be recorded.

Configuration
REQ-026 With macro POW_N_OVERFLOW_EN defined, the block SHALL add output down_ovf (1 bit).
REQ-027 down_ovf SHALL be 1 when any multiply for that item had a nonzero upper width bits in its full product; it SHALL be stored per stage alongside the item, cleared by reset, and 0 for n=1.
REQ-028 Without POW_N_OVERFLOW_EN, the port down_ovf and all overflow state SHALL be absent; the other behaviour SHALL be unchanged.

Verification (width=8, n=5 unless noted)
REQ-029 Single item: x=3, down_rdy=1 -> down_data=243 and down_vld=1 exactly 5 cycles after acceptance; down_ovf=0.
REQ-030 Wrap: x=4 -> down_data=0, down_ovf=1; x=255 -> down_data=255, down_ovf=1; x=0 -> 0; x=1 -> 1; x=2 -> 32, down_ovf=0.
REQ-031 Back-to-back stream 0..20 with down_rdy=1 -> one result per cycle, values (i^5 mod 256) in order.
REQ-032 Backpressure: down_rdy=0 for 10 cycles during a stream with up_vld=1 -> exactly 5 items accepted, then up_rdy=0; after down_rdy returns to 1, all results arrive in order with no gaps or duplicates; randomised up_vld/down_rdy gives the same checks.
REQ-033 Reset with 3 items in flight -> down_vld=0 and up_rdy=1 the next cycle; none of the 3 results ever appears.
REQ-034 n=1, width=4: x=9 -> down_data=9 one cycle later; n=2, width=4: x=5 -> down_data=9 (25 mod 16), down_ovf=1.

Source files
------------

// File: rtl/pow_n_pipelined_with_flow_control.sv
// n-stage valid/ready pipeline computing x^n mod 2^width, one multiply per stage.
// Define POW_N_OVERFLOW_EN to add down_ovf, flagging items whose product lost upper bits.
module pow_n_pipelined_with_flow_control #(
  parameter int width = 8,
  parameter int n     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [width-1:0] up_data,
  output logic             down_vld,
  input  logic             down_rdy,
  output logic [width-1:0] down_data
`ifdef POW_N_OVERFLOW_EN
  ,
  output logic             down_ovf
`endif
);

  logic [n-1:0]     vld;
  logic [n-1:0]     rdy;
  logic [width-1:0] xs [n];
  logic [width-1:0] ps [n];
`ifdef POW_N_OVERFLOW_EN
  logic [n-1:0]     ovf;
`endif

  // A stage is ready if it, or any stage after it, has a hole, or the sink takes data.
  // Built from an accumulator so the ready vector never feeds back on itself.
  always_comb begin : ready_chain
    logic acc;
    acc = down_rdy;
    rdy = '0;
    for (int i = n - 1; i >= 0; i--) begin
      acc    = acc | ~vld[i];
      rdy[i] = acc;
    end
  end

  assign up_rdy    = rdy[0];
  assign down_vld  = vld[n-1];
  assign down_data = ps[n-1];
`ifdef POW_N_OVERFLOW_EN
  assign down_ovf  = ovf[n-1];
`endif

  // NOTE: state is assigned with <= so every stage samples its predecessor's
  // pre-edge value; blocking assignments here would collapse the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      // NOTE: the data arrays are reset too, so down_data reads 0 after reset;
      // they are plain registers, not a RAM, so this costs no macro.
      for (int i = 0; i < n; i++) begin
        xs[i] <= '0;
        ps[i] <= '0;
      end
`ifdef POW_N_OVERFLOW_EN
      ovf <= '0;
`endif
    end else begin
      if (rdy[0]) begin
        vld[0] <= up_vld;
        if (up_vld) begin
          xs[0] <= up_data;
          ps[0] <= up_data;
`ifdef POW_N_OVERFLOW_EN
          ovf[0] <= 1'b0;
`endif
        end
      end
      // Payload only moves with a valid item, so empty slots keep stale data quiet.
      for (int k = 1; k < n; k++) begin
        if (rdy[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            xs[k] <= xs[k-1];
            ps[k] <= ps[k-1] * xs[k-1];
`ifdef POW_N_OVERFLOW_EN
            ovf[k] <= ovf[k-1] |
                      (|(({{width{1'b0}}, ps[k-1]} * {{width{1'b0}}, xs[k-1]}) >> width));
`endif
          end
        end
      end
    end
  end

endmodule
